// File: rtl/draw_char_start.sv
// draw_char_start: overlays a 16x16-character text box on the start-screen VGA stream.
// Stage 1 addresses the character/font ROMs, stage 2 waits for the glyph row, stage 3 paints.
module draw_char_start #(
   parameter int          XPOS     = 64,
   parameter int          YPOS     = 48,
   parameter logic [11:0] FG_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [10:0] vcount_in,
   input  logic [10:0] hcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   output logic [3:0]  char_line,
   input  logic [7:0]  char_pixels,
   output logic [10:0] vcount_out,
   output logic [10:0] hcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out
);
   // timing bus layout: {vcount[37:27], hcount[26:16], vsync, vblnk, hsync, hblnk, rgb[11:0]}
   logic [37:0] tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
   logic        en_frame_q, en_frame_d, en_frame2_q, en_frame2_d;
   logic        in_box_q, in_box_d, in_box2_q, in_box2_d;
   logic [2:0]  x_off_q, x_off_d, x_off2_q, x_off2_d;
   logic [7:0]  char_xy_q, char_xy_d;
   logic [3:0]  char_line_q, char_line_d;
   logic [6:0]  rel_x;
   logic [7:0]  rel_y;
   logic        paint;

   always_comb begin
      // only the low bits of the offsets are ever used, so subtract on those alone
      rel_x       = hcount_in[6:0] - 7'(XPOS);
      rel_y       = vcount_in[7:0] - 8'(YPOS);
      in_box_d    = {1'b0, hcount_in} >= 12'(XPOS) && {1'b0, hcount_in} < 12'(XPOS + 128) &&
                    {1'b0, vcount_in} >= 12'(YPOS) && {1'b0, vcount_in} < 12'(YPOS + 256);
      en_frame_d  = (vcount_in == 11'd0 && hcount_in == 11'd0) ? en : en_frame_q;
      char_xy_d   = in_box_d ? {rel_y[7:4], rel_x[6:3]} : 8'd0;
      char_line_d = in_box_d ? rel_y[3:0] : 4'd0;
      x_off_d     = rel_x[2:0];
      tim1_d      = {vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in, rgb_in};
      in_box2_d   = in_box_q;
      x_off2_d    = x_off_q;
      en_frame2_d = en_frame_q;
      tim2_d      = tim1_q;
      paint       = en_frame2_q && in_box2_q && !tim2_q[12] && !tim2_q[14] &&
                    char_pixels[3'd7 - x_off2_q];
      tim3_d      = {tim2_q[37:12], paint ? FG_COLOR : tim2_q[11:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tim1_q      <= '0;
         tim2_q      <= '0;
         tim3_q      <= '0;
         en_frame_q  <= 1'b0;
         en_frame2_q <= 1'b0;
         in_box_q    <= 1'b0;
         in_box2_q   <= 1'b0;
         x_off_q     <= '0;
         x_off2_q    <= '0;
         char_xy_q   <= '0;
         char_line_q <= '0;
      end else begin
         tim1_q      <= tim1_d;
         tim2_q      <= tim2_d;
         tim3_q      <= tim3_d;
         en_frame_q  <= en_frame_d;
         en_frame2_q <= en_frame2_d;
         in_box_q    <= in_box_d;
         in_box2_q   <= in_box2_d;
         x_off_q     <= x_off_d;
         x_off2_q    <= x_off2_d;
         char_xy_q   <= char_xy_d;
         char_line_q <= char_line_d;
      end
   end

   assign char_xy    = char_xy_q;
   assign char_line  = char_line_q;
   assign vcount_out = tim3_q[37:27];
   assign hcount_out = tim3_q[26:16];
   assign vsync_out  = tim3_q[15];
   assign vblnk_out  = tim3_q[14];
   assign hsync_out  = tim3_q[13];
   assign hblnk_out  = tim3_q[12];
   assign rgb_out    = tim3_q[11:0];
endmodule

// File: tb/tb_draw_char_start.sv
// tb_draw_char_start: directed vector table plus hand-written sequences for draw_char_start.
module tb_draw_char_start;
   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
   logic [11:0] rgb_in;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic [7:0]  char_pixels;
   logic [10:0] vcount_out, hcount_out;
   logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
   logic [11:0] rgb_out;
   int          pass_cnt = 0;
   int          total = 0;
   logic [11:0] r;

   typedef struct {
      logic [10:0] h, v;
      logic        hb, vb;
      logic [11:0] rgb;
      logic [7:0]  pix;
      logic [7:0]  xy;
      logic [3:0]  line;
      logic [11:0] exp;
   } vec_t;
   vec_t vec[13];

   draw_char_start dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .vcount_in(vcount_in), .hcount_in(hcount_in),
      .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .rgb_in(rgb_in), .char_xy(char_xy), .char_line(char_line), .char_pixels(char_pixels),
      .vcount_out(vcount_out), .hcount_out(hcount_out),
      .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask

   task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                        input logic vb, input logic [11:0] rgb);
      hcount_in = h;
      vcount_in = v;
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = rgb;
   endtask

   task automatic frame_start(input logic e);
      en = e;
      drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
      @(posedge clk); #1;
      drive(11'd0, 11'd1, 1'b0, 1'b0, 12'h000);
   endtask

   // one pixel through the pipe, glyph row presented two cycles later
   task automatic run1(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                       input logic [7:0] cp, output logic [11:0] res);
      drive(h, v, 1'b0, 1'b0, rgb);
      @(posedge clk); #1;
      drive(11'd0, 11'd1, 1'b0, 1'b0, 12'h000);
      @(posedge clk); #1;
      char_pixels = cp;
      @(posedge clk); #1;
      res = rgb_out;
      char_pixels = 8'h00;
   endtask

   initial begin
      vec[0]  = '{11'd120, 11'd48,  1'b0, 1'b0, 12'h123, 8'h00, 8'h07, 4'd0,  12'h123};
      vec[1]  = '{11'd120, 11'd48,  1'b0, 1'b0, 12'h123, 8'h80, 8'h07, 4'd0,  12'hFFF};
      vec[2]  = '{11'd121, 11'd48,  1'b0, 1'b0, 12'h123, 8'h80, 8'h07, 4'd0,  12'h123};
      vec[3]  = '{11'd191, 11'd303, 1'b0, 1'b0, 12'h123, 8'h01, 8'hFF, 4'd15, 12'hFFF};
      vec[4]  = '{11'd192, 11'd100, 1'b0, 1'b0, 12'h456, 8'hFF, 8'h00, 4'd0,  12'h456};
      vec[5]  = '{11'd100, 11'd304, 1'b0, 1'b0, 12'h789, 8'hFF, 8'h00, 4'd0,  12'h789};
      vec[6]  = '{11'd63,  11'd100, 1'b0, 1'b0, 12'hABC, 8'hFF, 8'h00, 4'd0,  12'hABC};
      vec[7]  = '{11'd100, 11'd47,  1'b0, 1'b0, 12'hDEF, 8'hFF, 8'h00, 4'd0,  12'hDEF};
      vec[8]  = '{11'd64,  11'd64,  1'b1, 1'b0, 12'h111, 8'h80, 8'h10, 4'd0,  12'h111};
      vec[9]  = '{11'd64,  11'd64,  1'b0, 1'b0, 12'h111, 8'h80, 8'h10, 4'd0,  12'hFFF};
      vec[10] = '{11'd70,  11'd70,  1'b0, 1'b0, 12'h222, 8'h02, 8'h10, 4'd6,  12'hFFF};
      vec[11] = '{11'd70,  11'd70,  1'b0, 1'b0, 12'h222, 8'hFD, 8'h10, 4'd6,  12'h222};
      vec[12] = '{11'd70,  11'd70,  1'b0, 1'b1, 12'h333, 8'hFF, 8'h10, 4'd6,  12'h333};

      rst_n = 1'b0; en = 1'b0; vsync_in = 1'b0; hsync_in = 1'b0; char_pixels = 8'h00;
      drive(11'd0, 11'd1, 1'b0, 1'b0, 12'h000);
      #3;
      chk("reset_rgb", 32'(rgb_out), 32'h0);
      chk("reset_hcount", 32'(hcount_out), 32'h0);
      chk("reset_char_xy", 32'(char_xy), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // outputs follow inputs exactly three cycles later after release
      for (int k = 0; k < 6; k++) begin
         drive(11'(500 + k), 11'(k + 1), 1'b0, 1'b0, 12'h000);
         @(posedge clk); #1;
         chk("release_track", 32'(hcount_out), k >= 2 ? 32'(500 + k - 2) : 32'h0);
      end

      // en high but no frame start since reset: no paint
      en = 1'b1;
      run1(11'd100, 11'd100, 12'h555, 8'hFF, r);
      chk("no_frame_after_reset", 32'(r), 32'h555);

      frame_start(1'b1);
      for (int c = 0; c < 15; c++) begin
         if (c < 13) drive(vec[c].h, vec[c].v, vec[c].hb, vec[c].vb, vec[c].rgb);
         else drive(11'd0, 11'd1, 1'b0, 1'b0, 12'h000);
         char_pixels = c >= 2 ? vec[c-2].pix : 8'h00;
         @(posedge clk); #1;
         if (c < 13) begin
            chk($sformatf("vec%0d_char_xy", c), 32'(char_xy), 32'(vec[c].xy));
            chk($sformatf("vec%0d_char_line", c), 32'(char_line), 32'(vec[c].line));
         end
         if (c >= 2) begin
            chk($sformatf("vec%0d_rgb_out", c - 2), 32'(rgb_out), 32'(vec[c-2].exp));
            chk($sformatf("vec%0d_hcount_out", c - 2), 32'(hcount_out), 32'(vec[c-2].h));
            chk($sformatf("vec%0d_vcount_out", c - 2), 32'(vcount_out), 32'(vec[c-2].v));
         end
      end
      char_pixels = 8'h00;

      hsync_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         hsync_in = 1'b0;
         chk($sformatf("hsync_pulse_%0d", k), 32'(hsync_out), k == 2 ? 32'h1 : 32'h0);
      end

      // reset mid-line with a full, busy pipeline
      drive(11'd100, 11'd100, 1'b0, 1'b0, 12'hABC);
      hsync_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_reset_rgb", 32'(rgb_out), 32'hABC);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_rgb", 32'(rgb_out), 32'h0);
      chk("async_reset_hsync", 32'(hsync_out), 32'h0);
      chk("async_reset_hcount", 32'(hcount_out), 32'h0);
      chk("async_reset_char_xy", 32'(char_xy), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      hsync_in = 1'b0;

      run1(11'd100, 11'd100, 12'h666, 8'hFF, r);
      chk("reset_clears_en_frame", 32'(r), 32'h666);
      frame_start(1'b0);
      en = 1'b1;
      run1(11'd100, 11'd100, 12'h777, 8'hFF, r);
      chk("en_raised_midframe", 32'(r), 32'h777);
      frame_start(1'b1);
      run1(11'd100, 11'd100, 12'h777, 8'hFF, r);
      chk("en_next_frame", 32'(r), 32'hFFF);
      en = 1'b0;
      run1(11'd100, 11'd100, 12'h777, 8'hFF, r);
      chk("en_dropped_midframe", 32'(r), 32'hFFF);
      frame_start(1'b0);
      run1(11'd100, 11'd100, 12'h777, 8'hFF, r);
      chk("en_off_next_frame", 32'(r), 32'h777);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/draw_char_start.md
# draw_char_start

Overlays a 16×16-character text box (8×16-pixel glyphs, 128×256 pixels) on the VGA pixel stream of the start screen. The block sits between the VGA timing/background stages and the output stage. It generates `char_xy` and `char_line` for the start-screen character ROM and the shared font ROM, then paints foreground pixels from the returned glyph row. All timing signals are delayed to stay aligned with the painted pixels.

## Interface
Parameters:
- `XPOS`, 64: left edge of the box, in pixels.
- `YPOS`, 48: top edge of the box, in pixels.
- `FG_COLOR`, 12'hF_F_F: glyph colour, 4:4:4 RGB.

Ports:
- `clk` input 1: pixel clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: overlay request, sampled once per frame.
- `vcount_in`, `hcount_in` input 11 each: pixel coordinates.
- `vsync_in`, `vblnk_in`, `hsync_in`, `hblnk_in` input 1 each: sync and blanking.
- `rgb_in` input 12: background pixel.
- `char_xy` output 8: address to the character ROM, {row[3:0], col[3:0]}.
- `char_line` output 4: glyph line to the font ROM.
- `char_pixels` input 8: font ROM row, valid 1 cycle after the address. MSB is the leftmost pixel.
- `vcount_out`, `hcount_out`, `vsync_out`, `vblnk_out`, `hsync_out`, `hblnk_out`, `rgb_out` output: same widths as the inputs, delayed by 3 cycles.

## Operation
- Frame latch:
  - `en_frame` is loaded from `en` only in the cycle where `vcount_in==0 && hcount_in==0`; it holds for the whole frame.
  - A change on `en` mid-frame has no visible effect until the next frame starts.
- Stage 1 (registered, T+1):
  - `in_box = hcount_in ≥ XPOS && hcount_in < XPOS+128 && vcount_in ≥ YPOS && vcount_in < YPOS+256`.
  - Compare in 12 bits so the bounds cannot overflow.
  - `rel_x = hcount_in − XPOS`; `rel_y = vcount_in − YPOS`, both 11-bit.
  - `char_xy = {rel_y[7:4], rel_x[6:3]}`; `char_line = rel_y[3:0]`; `x_off = rel_x[2:0]`.
  - When `in_box` is 0, `char_xy` and `char_line` are driven to 0.
- Character ROM: combinational `char_code`, external. The font ROM address {char_code, char_line} is presented during T+1.
- Stage 2 (T+2): `in_box`, `x_off` and `en_frame` are delayed one more cycle, aligning them with `char_pixels`.
- Stage 3 (registered output, T+3):
  - Paint condition: `en_frame_d2 && in_box_d2 && !hblnk_d2 && !vblnk_d2 && char_pixels[7−x_off_d2]`.
  - When the condition holds, `rgb_out = FG_COLOR`; otherwise `rgb_out = rgb_d2`.
- Timing bus: vcount, hcount, syncs, blanks and rgb pass through a 3-stage shift register.
- Clipping: a box extending past the visible area is clipped naturally by the blanking check; there is no wrap-around.

## Timing
- Latency: 3 clock cycles for every output relative to the inputs. `char_xy` and `char_line` have 1-cycle latency.
- Throughput: one pixel per cycle, no stalls, no handshake.
- Reset (`rst_n` low, asynchronous):
  - All pipeline registers, all outputs and `en_frame` go to 0 immediately.
  - The first valid output appears in the 3rd cycle after `rst_n` is released.
  - A reset mid-frame suppresses the overlay until the next frame start.
- Boundaries:
  - `hcount_in == XPOS+127` is the last in-box column (`col` 15, `x_off` 7).
  - `XPOS+128` is outside the box.
  - Likewise, `YPOS+255` is the last in-box line (`row` 15, `char_line` 15).
- Simultaneous events: if `en` changes in the frame-start cycle itself, the new value is taken.

## Test plan
- Reset: assert `rst_n=0` mid-line with active inputs → all outputs 0 in the same cycle. Release → outputs track inputs delayed by exactly 3 cycles.
- Addressing: `hcount_in=120`, `vcount_in=48` (XPOS=64, YPOS=48) → `char_xy=8'h07`, `char_line=0` one cycle later. `hcount_in=191`, `vcount_in=303` → `char_xy=8'hFF`, `char_line=15`.
- Box edges: `hcount_in=192` or `vcount_in=304`, with `char_pixels=8'hFF` → `char_xy=0` and `rgb_out` equals `rgb_in` from 3 cycles earlier. Repeat for `hcount_in=63` and `vcount_in=47`.
- Pixel select: in box with `x_off=0`, `char_pixels=8'h80`, `rgb_in=12'h123` → `rgb_out=12'hFFF`. Same stimulus with `x_off=1` → `rgb_out=12'h123`.
- Enable latch: raise `en` at `vcount_in=100` → no painting for the rest of that frame; painting starts in the next frame. Drop `en` mid-frame → painting continues until the frame ends.
- Timing alignment: a single-cycle `hsync_in` pulse at cycle N → `hsync_out` is high only at N+3. `hblnk_in` high inside the box → no painting.
